// File: rtl/mac_acc_param.sv
// Streaming multiply-accumulate over fixed-length windows.
// Two-stage product/accumulate pipeline with saturate or wrap overflow policy.
module mac_acc_param #(
  parameter int DATA_W  = 4,
  parameter int ACC_LEN = 9,
  parameter int OUT_W   = 12,
  parameter bit SAT_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in1_IFM,
  input  logic [DATA_W-1:0] in2_IFM,
  input  logic              mode_signed,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out,
  output logic              overflow
);

  localparam int PW = 2 * DATA_W;
  localparam int EW = OUT_W + 1 - PW;
  localparam logic [7:0] LAST = 8'(ACC_LEN - 1);

  localparam logic [OUT_W-1:0] MAX_U = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] MAX_S = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_S = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]       r_cnt;
  logic [PW-1:0]    r_prod;
  logic [OUT_W-1:0] r_acc;
  logic             r_mode;
  logic             r_ovf;
  logic [OUT_W-1:0] r_out;
  logic             r_out_v;
  logic             r_out_ovf;

  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic             w_mode;
  logic [PW-1:0]    w_op1;
  logic [PW-1:0]    w_op2;
  logic [PW-1:0]    w_prod;
  logic [OUT_W:0]   w_acc_x;
  logic [OUT_W:0]   w_prod_x;
  logic [OUT_W:0]   w_sum;
  logic             w_ovf;
  logic [OUT_W-1:0] w_acc_nx;

  assign w_accept = in_valid & in_ready;
  assign w_first  = w_accept & (r_state == S_IDLE);
  assign w_last   = (r_cnt == LAST);

  // The first beat uses the live mode; later beats the latched one.
  assign w_mode = (r_state == S_IDLE) ? mode_signed : r_mode;
  assign w_op1  = {{DATA_W{w_mode & in1_IFM[DATA_W-1]}}, in1_IFM};
  assign w_op2  = {{DATA_W{w_mode & in2_IFM[DATA_W-1]}}, in2_IFM};
  assign w_prod = w_op1 * w_op2;

  assign w_acc_x  = {r_mode & r_acc[OUT_W-1], r_acc};
  assign w_prod_x = {{EW{r_mode & r_prod[PW-1]}}, r_prod};
  assign w_sum    = w_acc_x + w_prod_x;

  // Out of range when the extra sum bit disagrees with the OUT_W result.
  assign w_ovf = r_mode ? (w_sum[OUT_W] ^ w_sum[OUT_W-1])
                        : w_sum[OUT_W];

  // Next accumulator value after the overflow policy.
  always_comb begin
    w_acc_nx = w_sum[OUT_W-1:0];
    if (SAT_EN && w_ovf) begin
      if (!r_mode)
        w_acc_nx = MAX_U;
      else if (w_sum[OUT_W])
        w_acc_nx = MIN_S;
      else
        w_acc_nx = MAX_S;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = w_last ? S_DRAIN : S_ACC;
      S_ACC:   if (w_accept && w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake output decoded from state.
  always_comb begin
    in_ready = 1'b0;
    unique case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_ACC:   in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Beat counter and per-window mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 8'd0;
      r_mode <= 1'b0;
    end else begin
      if (w_accept)
        r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
      if (w_first)
        r_mode <= mode_signed;
    end
  end

  // Product stage; bubbles feed a zero product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_prod <= '0;
    else
      r_prod <= w_accept ? w_prod : '0;
  end

  // Accumulate stage, cleared by the first beat of a window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_first) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_acc_nx;
      r_ovf <= r_ovf | w_ovf;
    end
  end

  // Result register, zero outside the single valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_out_v   <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (r_state == S_OUT) begin
      r_out     <= r_acc;
      r_out_v   <= 1'b1;
      r_out_ovf <= r_ovf;
    end else begin
      r_out     <= '0;
      r_out_v   <= 1'b0;
      r_out_ovf <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_v;
  assign overflow  = r_out_ovf;

endmodule

// File: tb/tb_mac_acc_param.sv
// Bench for mac_acc_param: default, saturating-10 and wrapping-10 instances
// driven in lockstep and compared against an arithmetic window model.
module tb_mac_acc_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       mode_signed;
  logic [3:0] in1;
  logic [3:0] in2;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        f0, f1, f2;
  logic [11:0] o0;
  logic [9:0]  o1;
  logic [9:0]  o2;

  int total = 0;
  int bad = 0;

  int qa[$];
  int qb[$];

  int o_out[3];
  int e_out[3];
  bit o_ovf[3];
  bit e_ovf[3];
  bit o_v[3];
  int o_lat;
  int o_after_out;
  bit o_tmo, o_rdy_bad, o_busy_rdy, o_after_v, o_after_rdy;

  always #5 clk = ~clk;

  mac_acc_param u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in1_IFM(in1), .in2_IFM(in2), .mode_signed(mode_signed),
    .out_valid(ov0), .out(o0), .overflow(f0)
  );

  mac_acc_param #(.OUT_W(10), .SAT_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in1_IFM(in1), .in2_IFM(in2), .mode_signed(mode_signed),
    .out_valid(ov1), .out(o1), .overflow(f1)
  );

  mac_acc_param #(.OUT_W(10), .SAT_EN(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in1_IFM(in1), .in2_IFM(in2), .mode_signed(mode_signed),
    .out_valid(ov2), .out(o2), .overflow(f2)
  );

  // Window result from plain integer arithmetic over qa/qb.
  function automatic void model(input bit sgn, input int w, input bit sat,
                                output int res, output bit ovf);
    longint acc, m, lo, hi, a, b;
    acc = 0;
    ovf = 0;
    m = longint'(1) << w;
    lo = sgn ? -(m / 2) : 0;
    hi = sgn ? (m / 2 - 1) : (m - 1);
    for (int i = 0; i < qa.size(); i++) begin
      a = qa[i];
      b = qb[i];
      if (sgn && a > 7) a -= 16;
      if (sgn && b > 7) b -= 16;
      acc += a * b;
      if (acc > hi || acc < lo) begin
        ovf = 1;
        if (sat) begin
          acc = (acc > hi) ? hi : lo;
        end else begin
          acc = (acc - lo) % m;
          if (acc < 0) acc += m;
          acc += lo;
        end
      end
    end
    res = int'(acc & (m - 1));
  endfunction

  function automatic void fill(input int n, input int a, input int b);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endfunction

  // Drives one window and records what the DUTs produced.
  task automatic run_window(input bit sgn, input int bub,
                            input bit tog, input bit junk);
    int i;
    int cyc;
    bit ph;
    i = 0;
    ph = 0;
    o_rdy_bad = 0;
    o_busy_rdy = 0;
    while (i < qa.size()) begin
      @(negedge clk);
      if (tog && i > 0) mode_signed = 1'($urandom);
      if ((bub == 1 && ph) || (bub == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 0;
        in1 = 4'($urandom);
        in2 = 4'($urandom);
        ph = 0;
      end else begin
        in_valid = 1;
        in1 = 4'(qa[i]);
        in2 = 4'(qb[i]);
        if (!(tog && i > 0)) mode_signed = sgn;
        if (!(rdy0 && rdy1 && rdy2)) o_rdy_bad = 1;
        @(posedge clk);
        i++;
        ph = 1;
      end
    end
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ov0 || cyc > 8) break;
      if (rdy0 || rdy1 || rdy2) o_busy_rdy = 1;
      in_valid = junk;
      in1 = 4'($urandom);
      in2 = 4'($urandom);
      mode_signed = 1'($urandom);
    end
    in_valid = 0;
    o_tmo = !ov0;
    o_lat = cyc;
    o_out[0] = int'(o0);
    o_out[1] = int'(o1);
    o_out[2] = int'(o2);
    o_ovf = '{f0, f1, f2};
    o_v = '{ov0, ov1, ov2};
    @(negedge clk);
    o_after_v = ov0 | ov1 | ov2;
    o_after_out = int'(o0) + int'(o1) + int'(o2);
    o_after_rdy = rdy0 & rdy1 & rdy2;
  endtask

  task automatic test_reset();
    rst_n = 0;
    in_valid = 0;
    mode_signed = 0;
    in1 = 0;
    in2 = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({ov0, ov1, ov2, f0, f1, f2} !== 6'b0 || o0 !== 12'd0 ||
        o1 !== 10'd0 || o2 !== 10'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b%b%b ovf=%b%b%b out=%0d/%0d/%0d exp zeros",
               ov0, ov1, ov2, f0, f1, f2, o0, o1, o2);
    end
    rst_n = 1;
    @(negedge clk);
    total++;
    if ({rdy0, rdy1, rdy2} !== 3'b111 || {ov0, ov1, ov2} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ready got rdy=%b%b%b v=%b%b%b exp rdy=111 v=000",
               rdy0, rdy1, rdy2, ov0, ov1, ov2);
    end
  endtask

  task automatic test_unsigned_max();
    fill(9, 15, 15);
    run_window(0, 0, 0, 0);
    e_out = '{2025, 1023, 1001};
    e_ovf = '{0, 1, 1};
    for (int d = 0; d < 3; d++) begin
      total++;
      if (o_out[d] !== e_out[d] || o_ovf[d] !== e_ovf[d]) begin
        bad++;
        $display("FAIL umax dut%0d got out=%0d ovf=%0d exp out=%0d ovf=%0d",
                 d, o_out[d], o_ovf[d], e_out[d], e_ovf[d]);
      end
    end
    total++;
    if (o_tmo || o_lat != 3 || o_rdy_bad || o_busy_rdy || !o_after_rdy ||
        o_after_v || o_after_out != 0 || o_v != '{1, 1, 1}) begin
      bad++;
      $display("FAIL umax_timing got lat=%0d tmo=%0d rdybad=%0d busy=%0d after v=%0d out=%0d rdy=%0d exp lat=3 after v=0 out=0 rdy=1",
               o_lat, o_tmo, o_rdy_bad, o_busy_rdy, o_after_v, o_after_out, o_after_rdy);
    end
  endtask

  task automatic test_signed();
    fill(9, 8, 7);
    run_window(1, 0, 0, 0);
    e_out = '{12'hE08, 520, 520};
    e_ovf = '{0, 0, 0};
    for (int d = 0; d < 3; d++) begin
      total++;
      if (o_out[d] !== e_out[d] || o_ovf[d] !== e_ovf[d]) begin
        bad++;
        $display("FAIL sneg dut%0d got out=%0d ovf=%0d exp out=%0d ovf=%0d",
                 d, o_out[d], o_ovf[d], e_out[d], e_ovf[d]);
      end
    end
    fill(9, 8, 8);
    run_window(1, 0, 0, 0);
    e_out = '{576, 511, 576};
    e_ovf = '{0, 1, 1};
    for (int d = 0; d < 3; d++) begin
      total++;
      if (o_out[d] !== e_out[d] || o_ovf[d] !== e_ovf[d]) begin
        bad++;
        $display("FAIL spos dut%0d got out=%0d ovf=%0d exp out=%0d ovf=%0d",
                 d, o_out[d], o_ovf[d], e_out[d], e_ovf[d]);
      end
    end
    total++;
    if (o_tmo || o_lat != 3 || o_rdy_bad || o_busy_rdy || !o_after_rdy ||
        o_after_v) begin
      bad++;
      $display("FAIL signed_timing got lat=%0d tmo=%0d rdybad=%0d busy=%0d after_v=%0d exp lat=3 clean",
               o_lat, o_tmo, o_rdy_bad, o_busy_rdy, o_after_v);
    end
  endtask

  task automatic test_bubbles();
    fill(9, 3, 2);
    run_window(0, 1, 1, 1);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (o_out[d] !== 54 || o_ovf[d] !== 1'b0) begin
        bad++;
        $display("FAIL bubbles dut%0d got out=%0d ovf=%0d exp out=54 ovf=0",
                 d, o_out[d], o_ovf[d]);
      end
    end
    total++;
    if (o_tmo || o_lat != 3 || o_rdy_bad || o_busy_rdy || !o_after_rdy ||
        o_after_v) begin
      bad++;
      $display("FAIL bubbles_timing got lat=%0d tmo=%0d rdybad=%0d busy=%0d after_v=%0d exp lat=3 clean",
               o_lat, o_tmo, o_rdy_bad, o_busy_rdy, o_after_v);
    end
  endtask

  task automatic test_wrap_clear();
    fill(9, 15, 15);
    run_window(0, 0, 0, 1);
    total++;
    if (o_out[2] !== 1001 || o_ovf[2] !== 1'b1) begin
      bad++;
      $display("FAIL wrap got out=%0d ovf=%0d exp out=1001 ovf=1",
               o_out[2], o_ovf[2]);
    end
    fill(9, 1, 1);
    run_window(0, 0, 0, 0);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (o_out[d] !== 9 || o_ovf[d] !== 1'b0) begin
        bad++;
        $display("FAIL clear dut%0d got out=%0d ovf=%0d exp out=9 ovf=0",
                 d, o_out[d], o_ovf[d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1;
      in1 = 4'd5;
      in2 = 4'd5;
      mode_signed = 0;
    end
    @(negedge clk);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    total++;
    if ({ov0, ov1, ov2} !== 3'b000 || o0 !== 12'd0 ||
        {rdy0, rdy1, rdy2} !== 3'b111) begin
      bad++;
      $display("FAIL reset_mid got v=%b%b%b out=%0d rdy=%b%b%b exp v=000 out=0 rdy=111",
               ov0, ov1, ov2, o0, rdy0, rdy1, rdy2);
    end
    @(negedge clk);
    rst_n = 1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov0 || ov1 || ov2) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_discard got pulses=%0d exp 0", pulses);
    end
    fill(9, 2, 2);
    run_window(0, 0, 0, 0);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (o_out[d] !== 36 || o_ovf[d] !== 1'b0 || o_lat != 3 || o_rdy_bad) begin
        bad++;
        $display("FAIL after_reset dut%0d got out=%0d ovf=%0d lat=%0d rdybad=%0d exp out=36 ovf=0 lat=3",
                 d, o_out[d], o_ovf[d], o_lat, o_rdy_bad);
      end
    end
  endtask

  task automatic test_random();
    bit sgn;
    int res;
    bit ovf;
    int ws[3] = '{12, 10, 10};
    bit ss[3] = '{1, 1, 0};
    for (int n = 0; n < 12; n++) begin
      sgn = 1'($urandom);
      qa.delete();
      qb.delete();
      for (int i = 0; i < 9; i++) begin
        qa.push_back(int'($urandom_range(0, 15)));
        qb.push_back(int'($urandom_range(0, 15)));
      end
      run_window(sgn, 2, 1'($urandom), 1'($urandom));
      for (int d = 0; d < 3; d++) begin
        model(sgn, ws[d], ss[d], res, ovf);
        total++;
        if (o_out[d] !== res || o_ovf[d] !== ovf) begin
          bad++;
          $display("FAIL random%0d dut%0d sgn=%0d got out=%0d ovf=%0d exp out=%0d ovf=%0d",
                   n, d, sgn, o_out[d], o_ovf[d], res, ovf);
        end
      end
      total++;
      if (o_tmo || o_lat != 3 || o_rdy_bad || o_busy_rdy || !o_after_rdy ||
          o_after_v) begin
        bad++;
        $display("FAIL random%0d_timing got lat=%0d tmo=%0d rdybad=%0d busy=%0d after_v=%0d exp lat=3 clean",
                 n, o_lat, o_tmo, o_rdy_bad, o_busy_rdy, o_after_v);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_bubbles();
    test_wrap_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
